uart_rx_cmd_decoder: RTL and testbench
======================================

// Module: uart_rx_cmd_decoder
// PURPOSE
//  Consumes bytes from the UART receive FSM (rx_data + single-cycle rx_data_valid) and parses host command frames.
//  Issues register-file write/read strobes and ALU start strobes.
//  Aborts partial frames on inter-byte timeout. Sits directly downstream of the RX FSM, upstream of the register file and ALU.
// PARAMETERS
//  DATA_W      8     byte width of rx_data / reg_wr_data
//  ADDR_W      4     register-file address width; addr = rx_data[ADDR_W-1:0] (upper bits ignored)
//  FUN_W       4     ALU function width; fun = rx_data[FUN_W-1:0]
//  TIMEOUT_CYC 4096  idle cycles allowed between bytes of one frame; 0 disables timeout
// PORTS
//  rx_clk        in   1       sole clock, rising edge
//  rst_n         in   1       synchronous, active-low reset
//  rx_data       in   DATA_W  received byte, valid only with rx_data_valid
//  rx_data_valid in   1       one-cycle pulse per good byte (error bytes never pulse)
//  reg_wr_en     out  1       one-cycle write strobe
//  reg_rd_en     out  1       one-cycle read strobe
//  reg_addr      out  ADDR_W  address qualifying reg_wr_en/reg_rd_en
//  reg_wr_data   out  DATA_W  write data qualifying reg_wr_en
//  alu_en        out  1       one-cycle ALU start strobe
//  alu_fun       out  FUN_W   ALU function qualifying alu_en
//  cmd_busy      out  1       high while a frame is partially received (state != IDLE)
//  cmd_error     out  1       one-cycle pulse: unknown opcode byte in IDLE
//  frame_error   out  1       one-cycle pulse: frame aborted by timeout
// BEHAVIOUR
//  - All outputs registered; on rst_n=0 at rx_clk edge: state=IDLE, every output and the timeout count = 0.
//  - Reset mid-frame discards the partial frame silently (no frame_error).
//  - Frames (opcode first): WR 0xAA,addr,data | RD 0xBB,addr | ALU_OP 0xCC,opA,opB,fun | ALU_NOP 0xDD,fun.
//  - States/transitions, each advancing only on rx_data_valid:
//    IDLE -AA-> WR_ADDR -> WR_DATA -> IDLE;  IDLE -BB-> RD_ADDR -> IDLE
//    IDLE -CC-> OPA -> OPB -> FUN -> IDLE;  IDLE -DD-> FUN -> IDLE
//    IDLE, other byte -> cmd_error pulse, stay IDLE.
//  - Latency: strobes assert in the cycle after the rx_data_valid of the completing byte, for exactly one cycle.
//  - WR_DATA byte: reg_wr_en, reg_addr=latched addr, reg_wr_data=byte.  RD_ADDR byte: reg_rd_en, reg_addr=byte.
//  - OPA byte: reg_wr_en to addr 0 with byte; OPB byte: reg_wr_en to addr 1 with byte.
//  - FUN byte: alu_en, alu_fun=byte[FUN_W-1:0].
//  - reg_addr/reg_wr_data/alu_fun hold last value when strobes low.
//  - Opcode values inside a frame are data, never re-decoded.
//  - Timeout: counter clears in IDLE and on every rx_data_valid; increments otherwise.
//    On reaching TIMEOUT_CYC: frame_error pulse next cycle, state->IDLE, no strobes.
//    Counter width $clog2(TIMEOUT_CYC+1), saturating; never wraps.
//  - Simultaneous rx_data_valid and timeout expiry in the same cycle: the byte wins; the counter clears.
//  - Back-to-back rx_data_valid on consecutive cycles is legal; each is a separate byte.
// STRUCTURE
//  - Package uart_cmd_pkg: opcode localparams (CMD_WR/RD/ALU_OP/ALU_NOP), state enum, operand addresses OPA_ADDR=0, OPB_ADDR=1.
//  - Sub-module frame_timeout_cnt (params TIMEOUT_CYC): inputs run, clear; output expired pulse.
//  - Top: state register, next-state comb, registered output logic.
// TESTING
//  1 AA,05,3C (gaps of 2 cycles) -> one reg_wr_en pulse, reg_addr=5, reg_wr_data=0x3C, 1 cycle after 3rd valid.
//  2 BB,0F -> reg_rd_en pulse, reg_addr=0xF.
//    Also BB,1F -> reg_addr=0xF (upper bits ignored).
//  3 CC,12,34,02 -> writes (0,0x12),(1,0x34), then alu_en with alu_fun=2.
//    Also DD,07 -> alu_en only, alu_fun=7.
//  4 Lone byte 0x55 in IDLE -> cmd_error 1 cycle, no strobes, cmd_busy stays 0.
//    Also AA,AA,AA -> write addr 0xA data 0xAA.
//  5 TIMEOUT_CYC=16: AA,05 then silence -> frame_error pulse 16 cycles after last valid, IDLE.
//    Byte on the expiry cycle -> frame continues.
//  6 rst_n low for 1 cycle after CC,12 -> no frame_error, all outputs 0.
//    Following DD,03 -> alu_en, alu_fun=3.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, parser states and fixed operand addresses for the UART command decoder.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_OPA,
    ST_OPB,
    ST_FUN
  } state_t;

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte idle counter; flags expiry while a frame is open and the limit has been reached.
module frame_timeout_cnt #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;

  // Saturates at LIMIT so a stalled frame can never wrap back below expiry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYC != 0) && run && (cnt == LIMIT);

endmodule

// File: rtl/uart_rx_cmd_decoder.sv
// Parses host command frames from the UART RX byte stream into register-file and ALU strobes.
module uart_rx_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int FUN_W       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              rx_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_data_valid,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              alu_en,
  output logic [FUN_W-1:0]  alu_fun,
  output logic              cmd_busy,
  output logic              cmd_error,
  output logic              frame_error
);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] wr_addr_lat, wr_addr_lat_nxt;
  logic              wr_en_nxt, rd_en_nxt, alu_en_nxt;
  logic              cmd_error_nxt, frame_error_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wr_data_nxt;
  logic [FUN_W-1:0]  fun_nxt;
  logic              frame_open, expired;

  assign frame_open = (state != ST_IDLE);

  frame_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (rx_clk),
    .rst_n  (rst_n),
    .run    (frame_open),
    .clear  (!frame_open || rx_data_valid),
    .expired(expired)
  );

  always_comb begin
    state_nxt       = state;
    wr_addr_lat_nxt = wr_addr_lat;
    wr_en_nxt       = 1'b0;
    rd_en_nxt       = 1'b0;
    alu_en_nxt      = 1'b0;
    cmd_error_nxt   = 1'b0;
    frame_error_nxt = 1'b0;
    addr_nxt        = reg_addr;
    wr_data_nxt     = reg_wr_data;
    fun_nxt         = alu_fun;

    // A byte arriving on the expiry cycle takes priority over the abort.
    if (rx_data_valid) begin
      unique case (state)
        ST_IDLE: begin
          case (rx_data)
            DATA_W'(CMD_WR):      state_nxt = ST_WR_ADDR;
            DATA_W'(CMD_RD):      state_nxt = ST_RD_ADDR;
            DATA_W'(CMD_ALU_OP):  state_nxt = ST_OPA;
            DATA_W'(CMD_ALU_NOP): state_nxt = ST_FUN;
            default:              cmd_error_nxt = 1'b1;
          endcase
        end
        ST_WR_ADDR: begin
          wr_addr_lat_nxt = rx_data[ADDR_W-1:0];
          state_nxt       = ST_WR_DATA;
        end
        ST_WR_DATA: begin
          wr_en_nxt   = 1'b1;
          addr_nxt    = wr_addr_lat;
          wr_data_nxt = rx_data;
          state_nxt   = ST_IDLE;
        end
        ST_RD_ADDR: begin
          rd_en_nxt = 1'b1;
          addr_nxt  = rx_data[ADDR_W-1:0];
          state_nxt = ST_IDLE;
        end
        ST_OPA: begin
          wr_en_nxt   = 1'b1;
          addr_nxt    = ADDR_W'(OPA_ADDR);
          wr_data_nxt = rx_data;
          state_nxt   = ST_OPB;
        end
        ST_OPB: begin
          wr_en_nxt   = 1'b1;
          addr_nxt    = ADDR_W'(OPB_ADDR);
          wr_data_nxt = rx_data;
          state_nxt   = ST_FUN;
        end
        ST_FUN: begin
          alu_en_nxt = 1'b1;
          fun_nxt    = rx_data[FUN_W-1:0];
          state_nxt  = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (expired) begin
      frame_error_nxt = 1'b1;
      state_nxt       = ST_IDLE;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      alu_en      <= 1'b0;
      alu_fun     <= '0;
      cmd_busy    <= 1'b0;
      cmd_error   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      reg_wr_en   <= wr_en_nxt;
      reg_rd_en   <= rd_en_nxt;
      reg_addr    <= addr_nxt;
      reg_wr_data <= wr_data_nxt;
      alu_en      <= alu_en_nxt;
      alu_fun     <= fun_nxt;
      cmd_busy    <= (state_nxt != ST_IDLE);
      cmd_error   <= cmd_error_nxt;
      frame_error <= frame_error_nxt;
    end
  end

  // The write-address latch is pure data and is always overwritten before use.
  always_ff @(posedge rx_clk) begin
    wr_addr_lat <= wr_addr_lat_nxt;
  end

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Directed bench for uart_rx_cmd_decoder with a short timeout so expiry is reachable.
module tb_uart_rx_cmd_decoder;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int FUN_W  = 4;
  localparam int TO_CYC = 16;

  logic              rx_clk;
  logic              rst_n;
  logic [DATA_W-1:0] rx_data;
  logic              rx_data_valid;
  logic              reg_wr_en, reg_rd_en, alu_en, cmd_busy, cmd_error, frame_error;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic [FUN_W-1:0]  alu_fun;

  int total = 0;
  int bad   = 0;

  uart_rx_cmd_decoder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUN_W(FUN_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .rx_clk       (rx_clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .reg_wr_en    (reg_wr_en),
    .reg_rd_en    (reg_rd_en),
    .reg_addr     (reg_addr),
    .reg_wr_data  (reg_wr_data),
    .alu_en       (alu_en),
    .alu_fun      (alu_fun),
    .cmd_busy     (cmd_busy),
    .cmd_error    (cmd_error),
    .frame_error  (frame_error)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte is held for one rising edge; returns at the falling edge just after it was sampled.
  task automatic send(input logic [7:0] b);
    @(negedge rx_clk);
    rx_data       = b;
    rx_data_valid = 1'b1;
    @(negedge rx_clk);
    rx_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge rx_clk);
  endtask

  // {wr_en, rd_en, alu_en, cmd_error, frame_error}
  function automatic logic [4:0] strobes();
    return {reg_wr_en, reg_rd_en, alu_en, cmd_error, frame_error};
  endfunction

  function automatic logic [21:0] all_outs();
    return {reg_wr_en, reg_rd_en, reg_addr, reg_wr_data, alu_en, alu_fun,
            cmd_busy, cmd_error, frame_error};
  endfunction

  logic fe_seen;

  initial begin
    rst_n         = 1'b0;
    rx_data       = '0;
    rx_data_valid = 1'b0;
    idle(3);
    check("reset_outputs", 32'(all_outs()), 32'h0);
    rst_n = 1'b1;

    // Write frame with 2-cycle gaps
    send(8'hAA);
    check("wr_busy_after_op", 32'(cmd_busy), 32'h1);
    check("wr_no_strobe_op", 32'(strobes()), 32'h0);
    idle(2);
    send(8'h05);
    idle(2);
    check("wr_no_strobe_addr", 32'(strobes()), 32'h0);
    send(8'h3C);
    check("wr_strobes", 32'(strobes()), 32'b10000);
    check("wr_addr", 32'(reg_addr), 32'h5);
    check("wr_data", 32'(reg_wr_data), 32'h3C);
    check("wr_busy_done", 32'(cmd_busy), 32'h0);
    idle(1);
    check("wr_pulse_one_cycle", 32'(strobes()), 32'h0);
    check("wr_addr_hold", 32'(reg_addr), 32'h5);

    // Read frames, upper address bits ignored
    send(8'hBB);
    send(8'h12);
    check("rd_strobes_a", 32'(strobes()), 32'b01000);
    check("rd_addr_a", 32'(reg_addr), 32'h2);
    send(8'hBB);
    send(8'h0F);
    check("rd_addr_b", 32'(reg_addr), 32'hF);
    send(8'hBB);
    send(8'h13);
    send(8'hBB);
    send(8'h1F);
    check("rd_strobes_c", 32'(strobes()), 32'b01000);
    check("rd_addr_upper_ign", 32'(reg_addr), 32'hF);

    // ALU operation frame
    send(8'hCC);
    send(8'h12);
    check("opa_strobes", 32'(strobes()), 32'b10000);
    check("opa_addr", 32'(reg_addr), 32'h0);
    check("opa_data", 32'(reg_wr_data), 32'h12);
    send(8'h34);
    check("opb_strobes", 32'(strobes()), 32'b10000);
    check("opb_addr", 32'(reg_addr), 32'h1);
    check("opb_data", 32'(reg_wr_data), 32'h34);
    check("opb_busy", 32'(cmd_busy), 32'h1);
    send(8'h02);
    check("fun_strobes", 32'(strobes()), 32'b00100);
    check("fun_value", 32'(alu_fun), 32'h2);
    check("fun_data_hold", 32'(reg_wr_data), 32'h34);

    // ALU NOP sent back-to-back on consecutive cycles
    @(negedge rx_clk);
    rx_data       = 8'hDD;
    rx_data_valid = 1'b1;
    @(negedge rx_clk);
    check("nop_op_busy", 32'(cmd_busy), 32'h1);
    check("nop_op_no_strobe", 32'(strobes()), 32'h0);
    rx_data = 8'h07;
    @(negedge rx_clk);
    rx_data_valid = 1'b0;
    check("nop_strobes", 32'(strobes()), 32'b00100);
    check("nop_fun", 32'(alu_fun), 32'h7);

    // Unknown opcode, then opcode values used as payload
    send(8'h55);
    check("unk_strobes", 32'(strobes()), 32'b00010);
    check("unk_busy", 32'(cmd_busy), 32'h0);
    idle(1);
    check("unk_pulse_one_cycle", 32'(cmd_error), 32'h0);
    send(8'hAA);
    send(8'hAA);
    check("aa_payload_busy", 32'(cmd_busy), 32'h1);
    send(8'hAA);
    check("aa_strobes", 32'(strobes()), 32'b10000);
    check("aa_addr", 32'(reg_addr), 32'hA);
    check("aa_data", 32'(reg_wr_data), 32'hAA);

    // Timeout abort: error appears on the cycle after 16 idle cycles
    send(8'hAA);
    send(8'h05);
    idle(TO_CYC);
    check("to_not_early", 32'(frame_error), 32'h0);
    check("to_busy_before", 32'(cmd_busy), 32'h1);
    idle(1);
    check("to_strobes", 32'(strobes()), 32'b00001);
    check("to_busy_after", 32'(cmd_busy), 32'h0);
    idle(1);
    check("to_pulse_one_cycle", 32'(frame_error), 32'h0);

    // Byte landing on the expiry cycle keeps the frame alive
    send(8'hAA);
    send(8'h05);
    idle(TO_CYC - 1);
    send(8'h77);
    check("expiry_byte_strobes", 32'(strobes()), 32'b10000);
    check("expiry_byte_addr", 32'(reg_addr), 32'h5);
    check("expiry_byte_data", 32'(reg_wr_data), 32'h77);

    // Mid-frame reset discards silently
    send(8'hCC);
    send(8'h12);
    @(negedge rx_clk);
    rst_n = 1'b0;
    @(negedge rx_clk);
    rst_n = 1'b1;
    check("midrst_outputs", 32'(all_outs()), 32'h0);
    fe_seen = 1'b0;
    for (int i = 0; i < TO_CYC + 4; i++) begin
      @(negedge rx_clk);
      fe_seen = fe_seen | frame_error | cmd_busy;
    end
    check("midrst_no_frame_err", 32'(fe_seen), 32'h0);
    send(8'hDD);
    send(8'h03);
    check("post_rst_strobes", 32'(strobes()), 32'b00100);
    check("post_rst_fun", 32'(alu_fun), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
